dram_fifo33: RTL and testbench

//   Synchronous FIFO with valid/ready handshake on both sides.

---
 rtl/dram_fifo_pkg.sv | 15 +
 rtl/dram32_bank.sv | 37 +++
 rtl/ram32x1d.sv | 38 +++
 rtl/dram_fifo33.sv | 102 ++++++++++
 tb/tb_dram_fifo33.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_fifo_pkg.sv
// Shared sizing for the 33-word distributed-RAM FIFO: 32 RAM entries plus
// one registered output word.
package dram_fifo_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 6;
    localparam int CAP    = DEPTH + 1;

    // Pointers wrap 31 -> 0 through natural 5-bit overflow.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/dram32_bank.sv
// DATA_W-wide, 32-deep storage: one 32x1 dual-port RAM per data bit, all
// sharing the write clock, write enable, write address and read address.
module dram32_bank
    import dram_fifo_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd_o
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        RAM32X1D #(
            .INIT (32'h0000_0000)
        ) u_ram (
            .DPO   (rd_o[i]),
            .A0    (wa_i[0]),
            .A1    (wa_i[1]),
            .A2    (wa_i[2]),
            .A3    (wa_i[3]),
            .A4    (wa_i[4]),
            .D     (wd_i[i]),
            .DPRA0 (ra_i[0]),
            .DPRA1 (ra_i[1]),
            .DPRA2 (ra_i[2]),
            .DPRA3 (ra_i[3]),
            .DPRA4 (ra_i[4]),
            .WCLK  (clk_i),
            .WE    (we_i)
        );
    end

endmodule

// File: rtl/ram32x1d.sv
// Behavioural stand-in for the 32x1 dual-port distributed-RAM primitive:
// synchronous write on port A, asynchronous read on DPRA.
module RAM32X1D #(
    parameter logic [31:0] INIT = 32'h0000_0000
) (
    output logic DPO,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic D,
    input  logic DPRA0,
    input  logic DPRA1,
    input  logic DPRA2,
    input  logic DPRA3,
    input  logic DPRA4,
    input  logic WCLK,
    input  logic WE
);

    // Cells hold data XOR INIT, so all-zero power-up storage reads back as INIT.
    logic [31:0] mem_q;
    logic [4:0]  wa;
    logic [4:0]  ra;

    assign wa = {A4, A3, A2, A1, A0};
    assign ra = {DPRA4, DPRA3, DPRA2, DPRA1, DPRA0};

    always_ff @(posedge WCLK) begin
        if (WE) begin
            mem_q[wa] <= D ^ INIT[wa];
        end
    end

    assign DPO = mem_q[ra] ^ INIT[ra];

endmodule

// File: rtl/dram_fifo33.sv
// 33-word first-word-fall-through FIFO: 32 words in distributed RAM plus a
// registered head word. Holds pointers, RAM occupancy and the output stage.
module dram_fifo33
    import dram_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int AF_THRESH = 28
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [DATA_W-1:0] dpo;
    logic              wr_acc;
    logic              load;
    logic              ram_we;

    assign wr_ready_o = (ram_cnt_q != CNT_W'(DEPTH));
    assign wr_acc     = wr_valid_i & wr_ready_o;
    assign load       = (ram_cnt_q != '0) & (~out_vld_q | rd_ready_i);
    // A flush drops the concurrent write, so keep it out of the RAM too.
    assign ram_we     = wr_acc & ~clr_i;

    dram32_bank #(
        .DATA_W (DATA_W)
    ) u_bank (
        .clk_i (clk_i),
        .we_i  (ram_we),
        .wa_i  (wr_ptr_q),
        .ra_i  (rd_ptr_q),
        .wd_i  (wr_data_i),
        .rd_o  (dpo)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        out_vld_d = out_vld_q;
        rd_data_d = rd_data_q;
        if (clr_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            out_vld_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (load) begin
                rd_ptr_d  = ptr_inc(rd_ptr_q);
                rd_data_d = dpo;
                out_vld_d = 1'b1;
            end else if (rd_ready_i && out_vld_q) begin
                out_vld_d = 1'b0;
            end
            ram_cnt_d = ram_cnt_q + CNT_W'(wr_acc) - CNT_W'(load);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            out_vld_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            out_vld_q <= out_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Flags decode registers only; no input reaches them combinationally.
    assign level_o       = ram_cnt_q + CNT_W'(out_vld_q);
    assign rd_valid_o    = out_vld_q;
    assign rd_data_o     = rd_data_q;
    assign full_o        = (level_o == CNT_W'(CAP));
    assign empty_o       = (level_o == '0);
    assign almost_full_o = (level_o >= CNT_W'(AF_THRESH));

endmodule

// File: tb/tb_dram_fifo33.sv
// Self-checking bench for dram_fifo33: a short vector table plus scoreboarded
// fill, stream, random back-pressure, flush and async-reset sequences.
`timescale 1ns/1ps
module tb_dram_fifo33;

    localparam int DW  = 8;
    localparam int AFT = 28;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wv;
    logic          rr;
    logic [DW-1:0] wd;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [5:0]    level;
    logic          full;
    logic          empty;
    logic          afull;

    dram_fifo33 #(.DATA_W(DW), .AF_THRESH(AFT)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .clr_i         (clr),
        .wr_valid_i    (wv),
        .wr_ready_o    (wr_ready),
        .wr_data_i     (wd),
        .rd_valid_o    (rd_valid),
        .rd_ready_i    (rr),
        .rd_data_o     (rd_data),
        .level_o       (level),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (afull)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          last_wr_fire;
    logic          last_rv;
    int            got = 0;

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        int            lvl;
        logic          rv;
        logic [DW-1:0] rdat;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check against the scoreboard at the falling edge, then
    // advance to just past the rising edge.
    task automatic step();
        logic [DW-1:0] e;
        @(negedge clk);
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("full", 32'(full), 32'(exp_q.size() == 33));
        chk("empty", 32'(empty), 32'(exp_q.size() == 0));
        chk("almost_full", 32'(afull), 32'(exp_q.size() >= AFT));
        if (prev_hold) begin
            chk("hold_valid", 32'(rd_valid), 32'd1);
            chk("hold_data", 32'(rd_data), 32'(prev_data));
        end
        prev_hold    = rd_valid & ~rr & ~clr;
        prev_data    = rd_data;
        last_rv      = rd_valid;
        last_wr_fire = wv & wr_ready & ~clr;
        if (clr) begin
            exp_q.delete();
        end else begin
            if (rd_valid && rr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e));
                end
                got++;
            end
            if (last_wr_fire) exp_q.push_back(wd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_to(input int n, input logic [DW-1:0] base);
        int budget = 0;
        rr = 1'b0;
        wv = 1'b1;
        wd = base;
        while (exp_q.size() < n && budget < 200) begin
            step();
            if (last_wr_fire) wd = wd + 1'b1;
            budget++;
        end
        wv = 1'b0;
        if (budget >= 200) chk("fill_timeout", 32'(exp_q.size()), 32'(n));
    endtask

    task automatic drain();
        int budget = 0;
        wv = 1'b0;
        rr = 1'b1;
        while ((exp_q.size() != 0 || rd_valid) && budget < 200) begin
            step();
            budget++;
        end
        rr = 1'b0;
        if (budget >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        int budget;
        int sent;
        int pre;
        logic first_seen;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'hA5};
        tbl[2] = '{1'b1, 8'h3C, 1'b0, 2, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h3C};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h3C};
        tbl[5] = '{1'b1, 8'h77, 1'b1, 1, 1'b0, 8'h3C};
        tbl[6] = '{1'b1, 8'h88, 1'b1, 2, 1'b1, 8'h77};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h88};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h88};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h88};

        rst_n = 1'b0;
        clr   = 1'b0;
        wv    = 1'b0;
        rr    = 1'b0;
        wd    = '0;
        #23;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(afull), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: latency, FWFT pass-through, simultaneous read/write.
        for (int i = 0; i < 10; i++) begin
            wv = tbl[i].wv;
            wd = tbl[i].wd;
            rr = tbl[i].rr;
            step();
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_rv", i), 32'(rd_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rdata", i), 32'(rd_data), 32'(tbl[i].rdat));
        end
        wv = 1'b0;
        rr = 1'b0;

        // Fill to capacity with almost-full threshold checks.
        acc = 0;
        budget = 0;
        rr = 1'b0;
        wv = 1'b1;
        wd = 8'h40;
        while (acc < 33 && budget < 100) begin
            step();
            if (last_wr_fire) begin
                acc++;
                wd = 8'h40 + 8'(acc);
                if (acc == AFT - 1) chk("af_below", 32'(afull), 32'd0);
                if (acc == AFT)     chk("af_at", 32'(afull), 32'd1);
            end
            budget++;
        end
        chk("fill_count", 32'(acc), 32'd33);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_level", 32'(level), 32'd33);
        step();
        chk("34th_rejected", 32'(last_wr_fire), 32'd0);
        chk("34th_level", 32'(level), 32'd33);
        drain();

        // Streaming 0..99 at full rate in both directions.
        got = 0;
        sent = 0;
        first_seen = 1'b0;
        budget = 0;
        wv = 1'b1;
        rr = 1'b1;
        wd = 8'd0;
        while (got < 100 && budget < 400) begin
            pre = got;
            step();
            if (last_wr_fire) begin
                sent++;
                wd = 8'(sent);
                if (sent == 100) wv = 1'b0;
            end
            if (last_rv) first_seen = 1'b1;
            if (first_seen && pre < 100) chk("no_bubble", 32'(last_rv), 32'd1);
            budget++;
        end
        chk("stream_count", 32'(got), 32'd100);
        drain();

        // Random producer and consumer, 200 words.
        got = 0;
        sent = 0;
        budget = 0;
        wd = 8'($urandom);
        wv = 1'b1;
        while (got < 200 && budget < 5000) begin
            rr = 1'($urandom_range(0, 1));
            step();
            if (last_wr_fire) begin
                sent++;
                wd = 8'($urandom);
            end
            wv = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            budget++;
        end
        chk("random_count", 32'(got), 32'd200);
        drain();

        // Flush with a concurrent write: that word must never appear.
        fill_to(10, 8'h20);
        chk("pre_clr_level", 32'(level), 32'd10);
        clr = 1'b1;
        wv  = 1'b1;
        wd  = 8'hEE;
        step();
        clr = 1'b0;
        wv  = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_rd_valid", 32'(rd_valid), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        fill_to(3, 8'h11);
        drain();

        // Asynchronous reset between clock edges.
        fill_to(20, 8'h60);
        chk("pre_rst_level", 32'(level), 32'd20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        exp_q.delete();
        prev_hold = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_to(4, 8'hC0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
